lab_func_seq: RTL and testbench



---
 rtl/lab_func_pkg.sv | 21 ++
 rtl/lab_func_lane.sv | 27 ++
 rtl/lab_func_seq.sv | 144 ++++++++++++++
 tb/tb_lab_func_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/lab_func_pkg.sv
// Purpose: shared types for the sequential Boolean lab unit (function select, FSM states).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lab_func_pkg;

   // Bitwise function applied lane by lane.
   typedef enum logic [1:0] {
      FUNC_AND  = 2'b00,
      FUNC_OR   = 2'b01,
      FUNC_XOR  = 2'b10,
      FUNC_NAND = 2'b11
   } func_sel_t;

   // Control FSM states of lab_func_seq.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/lab_func_lane.sv
// Purpose: combinational LANES-bit slice of the selected bitwise function.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller sequences the slices.
module lab_func_lane
   import lab_func_pkg::*;
#(
   parameter int LANES = 2
) (
   input  logic [LANES-1:0] a,
   input  logic [LANES-1:0] b,
   input  func_sel_t        sel,
   output logic [LANES-1:0] y
);

   // Apply the selected function to one slice of the operands.
   always_comb begin
      y = '0;
      unique case (sel)
         FUNC_AND:  y = a & b;
         FUNC_OR:   y = a | b;
         FUNC_XOR:  y = a ^ b;
         FUNC_NAND: y = ~(a & b);
         default:   y = '0;
      endcase
   end

endmodule

// File: rtl/lab_func_seq.sv
// Purpose: sequential bitwise AND/OR/XOR/NAND unit with sticky OR-accumulator; parity port when LAB_FUNC_PARITY_EN is defined.
// Latency: WIDTH/LANES cycles from acceptance to done_valid; one request per WIDTH/LANES+2 cycles.
// Backpressure: start_ready only in IDLE; result and done_valid held in DONE until done_ready.
module lab_func_seq
   import lab_func_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       sel,
   input  logic             clr,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] f0,
   output logic [WIDTH-1:0] f1
`ifdef LAB_FUNC_PARITY_EN
   ,
   output logic             parity
`endif
);

   localparam int BEATS = WIDTH / LANES;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   // Operands must split into whole beats.
   generate
      if ((LANES < 1) || (WIDTH % LANES != 0)) begin : g_bad_cfg
         $error("lab_func_seq: WIDTH (%0d) must be a multiple of LANES (%0d)", WIDTH, LANES);
      end
   endgenerate

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   func_sel_t        sel_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_full;
   logic [LANES-1:0] lane_a;
   logic [LANES-1:0] lane_b;
   logic [LANES-1:0] lane_y;
   logic             accept;
   logic             last_beat;

   // One shared lane evaluator, steered by the beat counter.
   assign lane_a = a_q[int'(cnt)*LANES +: LANES];
   assign lane_b = b_q[int'(cnt)*LANES +: LANES];

   lab_func_lane #(
      .LANES (LANES)
   ) u_lane (
      .a   (lane_a),
      .b   (lane_b),
      .sel (sel_q),
      .y   (lane_y)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake decode; outputs depend only on the state register.
   always_comb begin
      state_nxt   = state;
      start_ready = 1'b0;
      done_valid  = 1'b0;
      accept      = 1'b0;
      last_beat   = 1'b0;
      unique case (state)
         IDLE: begin
            start_ready = 1'b1;
            accept      = start_valid;
            if (start_valid) state_nxt = RUN;
         end
         RUN: begin
            last_beat = (cnt == LAST_BEAT);
            if (cnt == LAST_BEAT) state_nxt = DONE;
         end
         DONE: begin
            done_valid = 1'b1;
            if (done_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Partial result with the current beat's slice merged in; complete on the last beat.
   always_comb begin
      res_full = res_q;
      res_full[int'(cnt)*LANES +: LANES] = lane_y;
   end

   // Operand latch and beat sequencing; later input changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         sel_q <= FUNC_AND;
         cnt   <= '0;
         res_q <= '0;
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         sel_q <= func_sel_t'(sel);
         cnt   <= '0;
         res_q <= '0;
      end else if (state == RUN) begin
         res_q <= res_full;
         cnt   <= last_beat ? '0 : cnt + CNT_W'(1);
      end
   end

   // Published result and accumulator; clr in the completion cycle clears before OR-ing.
   always_ff @(posedge clk) begin
      if (rst) begin
         f0 <= '0;
         f1 <= '0;
      end else if (last_beat) begin
         f0 <= res_full;
         f1 <= (clr ? '0 : f1) | res_full;
      end else if (clr) begin
         f1 <= '0;
      end
   end

`ifdef LAB_FUNC_PARITY_EN
   // Parity tracks f0, updated in the same completion cycle.
   always_ff @(posedge clk) begin
      if (rst)            parity <= 1'b0;
      else if (last_beat) parity <= ^res_full;
   end
`endif

endmodule

// File: tb/tb_lab_func_seq.sv
// Purpose: directed self-checking bench for lab_func_seq (WIDTH=8, LANES=2).
// Latency: expects done_valid 4 cycles after acceptance.
// Backpressure: exercises done_ready held low and released.
module tb_lab_func_seq;
   import lab_func_pkg::*;

   localparam int WIDTH = 8;
   localparam int LANES = 2;
   localparam int BEATS = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [1:0]       sel;
   logic             clr;
   logic             done_valid;
   logic             done_ready;
   logic [WIDTH-1:0] f0;
   logic [WIDTH-1:0] f1;
`ifdef LAB_FUNC_PARITY_EN
   logic             parity;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   lab_func_seq #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .sel         (sel),
      .clr         (clr),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .f0          (f0),
      .f1          (f1)
`ifdef LAB_FUNC_PARITY_EN
      ,
      .parity      (parity)
`endif
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request, scramble inputs after acceptance, check result and handshakes.
   task automatic run_req(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] ts,
                          input logic [7:0] ef0, input logic [7:0] ef1,
                          input int hold, input bit clr_done);
      int         cyc;
      logic [7:0] prev;
      prev        = f0;
      done_ready  = (hold == 0);
      start_valid = 1'b1;
      a           = ta;
      b           = tb_v;
      sel         = ts;
      @(negedge clk);
      start_valid = 1'b0;
      a           = ~ta;
      b           = ~tb_v;
      sel         = ts ^ 2'b11;
      chk("busy_start_ready", {31'd0, start_ready}, 32'd0);
      chk("f0_held_in_run", {24'd0, f0}, {24'd0, prev});
      cyc = 0;
      while (!done_valid && cyc < 20) begin
         if (cyc == BEATS - 1) clr = clr_done;
         @(negedge clk);
         cyc++;
         clr = 1'b0;
      end
      chk("latency", cyc, BEATS);
      chk("f0", {24'd0, f0}, {24'd0, ef0});
      chk("f1", {24'd0, f1}, {24'd0, ef1});
`ifdef LAB_FUNC_PARITY_EN
      chk("parity", {31'd0, parity}, {31'd0, ^ef0});
`endif
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_done_valid", {31'd0, done_valid}, 32'd1);
         chk("hold_f0", {24'd0, f0}, {24'd0, ef0});
         chk("hold_start_ready", {31'd0, start_ready}, 32'd0);
      end
      done_ready = 1'b1;
      @(negedge clk);
      chk("release_done_valid", {31'd0, done_valid}, 32'd0);
      chk("release_start_ready", {31'd0, start_ready}, 32'd1);
   endtask

   // Hard stop if the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Directed sequence.
   initial begin
      logic seen;
      rst         = 1'b1;
      start_valid = 1'b0;
      a           = '0;
      b           = '0;
      sel         = 2'b00;
      clr         = 1'b0;
      done_ready  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_start_ready", {31'd0, start_ready}, 32'd1);
      chk("reset_done_valid", {31'd0, done_valid}, 32'd0);
      chk("reset_f0", {24'd0, f0}, 32'd0);
      chk("reset_f1", {24'd0, f1}, 32'd0);
`ifdef LAB_FUNC_PARITY_EN
      chk("reset_parity", {31'd0, parity}, 32'd0);
`endif

      run_req(8'hF0, 8'h3C, 2'b00, 8'h30, 8'h30, 0, 1'b0);
      run_req(8'h01, 8'h02, 2'b01, 8'h03, 8'h33, 0, 1'b0);
      run_req(8'hFF, 8'hFF, 2'b11, 8'h00, 8'h33, 3, 1'b0);
      run_req(8'hA5, 8'hFF, 2'b10, 8'h5A, 8'h5A, 0, 1'b1);
      run_req(8'h01, 8'h00, 2'b01, 8'h01, 8'h5B, 0, 1'b0);

      // Reset during beat 2 of an in-flight request.
      start_valid = 1'b1;
      a           = 8'hFF;
      b           = 8'h0F;
      sel         = 2'b00;
      done_ready  = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrun_rst_start_ready", {31'd0, start_ready}, 32'd1);
      chk("midrun_rst_done_valid", {31'd0, done_valid}, 32'd0);
      chk("midrun_rst_f0", {24'd0, f0}, 32'd0);
      chk("midrun_rst_f1", {24'd0, f1}, 32'd0);
`ifdef LAB_FUNC_PARITY_EN
      chk("midrun_rst_parity", {31'd0, parity}, 32'd0);
`endif
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | done_valid;
      end
      chk("no_spurious_done", {31'd0, seen}, 32'd0);

      run_req(8'h0F, 8'hFF, 2'b00, 8'h0F, 8'h0F, 0, 1'b0);

      // clr while idle clears only the accumulator.
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("idle_clr_f1", {24'd0, f1}, 32'd0);
      chk("idle_clr_f0", {24'd0, f0}, 32'h0F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
